// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: bus widths, default error data and the
// one-hot state encoding used by the slave mux FSM.
package wb_pkg;

    localparam int WB_ADR_W = 36;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    localparam logic [WB_DAT_W-1:0] WB_ERR_DATA = 32'hDEADBEEF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b001,
        ST_ACTIVE = 3'b010,
        ST_ACK    = 3'b100
    } wb_state_e;

endpackage

// File: rtl/wb_addr_decode.sv
// Combinational mask/base address decoder; the lowest-index matching slave wins.
module wb_addr_decode
    import wb_pkg::*;
#(
    parameter int                          NSLAVES    = 4,
    parameter logic [WB_ADR_W*NSLAVES-1:0] SLAVE_BASE = '0,
    parameter logic [WB_ADR_W*NSLAVES-1:0] SLAVE_MASK = '0
) (
    input  logic [WB_ADR_W-1:0] adr,
    output logic [NSLAVES-1:0]  hit,
    output logic                valid
);

    // Walk downwards so a lower-index match overwrites any higher one.
    always_comb begin
        hit = '0;
        for (int i = NSLAVES - 1; i >= 0; i--) begin
            if ((adr & SLAVE_MASK[WB_ADR_W*i +: WB_ADR_W]) == SLAVE_BASE[WB_ADR_W*i +: WB_ADR_W]) begin
                hit    = '0;
                hit[i] = 1'b1;
            end
        end
    end

    assign valid = |hit;

endmodule

// File: rtl/wb_slave_mux.sv
// Wishbone 1-to-NSLAVES interconnect stage; unmapped or silent slaves are
// completed with ERR_DATA so the master can never hang.
module wb_slave_mux
    import wb_pkg::*;
#(
    parameter int                          NSLAVES    = 4,
    parameter logic [WB_ADR_W*NSLAVES-1:0] SLAVE_BASE = '0,
    parameter logic [WB_ADR_W*NSLAVES-1:0] SLAVE_MASK = '0,
    parameter int                          TIMEOUT    = 255,
    parameter logic [WB_DAT_W-1:0]         ERR_DATA   = WB_ERR_DATA
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [WB_ADR_W-1:0]         m_adr_i,
    input  logic [WB_DAT_W-1:0]         m_dat_i,
    input  logic                        m_we_i,
    input  logic [WB_SEL_W-1:0]         m_sel_i,
    input  logic                        m_stb_i,
    input  logic                        m_cyc_i,
    output logic [WB_DAT_W-1:0]         m_dat_o,
    output logic                        m_ack_o,
    output logic [WB_ADR_W-1:0]         s_adr_o,
    output logic [WB_DAT_W-1:0]         s_dat_o,
    output logic                        s_we_o,
    output logic [WB_SEL_W-1:0]         s_sel_o,
    output logic [NSLAVES-1:0]          s_stb_o,
    output logic [NSLAVES-1:0]          s_cyc_o,
    input  logic [WB_DAT_W*NSLAVES-1:0] s_dat_i,
    input  logic [NSLAVES-1:0]          s_ack_i,
    output logic                        err_flag,
    output logic [WB_ADR_W-1:0]         err_adr,
    output logic                        err_timeout,
    input  logic                        err_clr
);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    wb_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NSLAVES-1:0]    hit, stb_d;
    logic                  hit_vld;
    logic                  slv_ack;
    logic [WB_DAT_W-1:0]   slv_dat, dat_d;
    logic                  ack_d, ld_bus, err_set, err_to_d, flag_d;
    logic [WB_ADR_W-1:0]   err_adr_d;

    wb_addr_decode #(
        .NSLAVES    (NSLAVES),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_decode (
        .adr   (m_adr_i),
        .hit   (hit),
        .valid (hit_vld)
    );

    // The held one-hot strobe doubles as the slave select for ack and read data.
    assign slv_ack = |(s_ack_i & s_stb_o);

    always_comb begin
        slv_dat = '0;
        for (int i = 0; i < NSLAVES; i++) begin
            if (s_stb_o[i])
                slv_dat = slv_dat | s_dat_i[WB_DAT_W*i +: WB_DAT_W];
        end
    end

    always_comb begin
        state_d   = state_q;
        stb_d     = s_stb_o;
        cnt_d     = cnt_q;
        ack_d     = 1'b0;
        dat_d     = m_dat_o;
        ld_bus    = 1'b0;
        err_set   = 1'b0;
        err_to_d  = err_timeout;
        err_adr_d = err_adr;
        case (state_q)
            ST_IDLE: begin
                if (m_cyc_i && m_stb_i) begin
                    ld_bus = 1'b1;
                    if (hit_vld) begin
                        state_d = ST_ACTIVE;
                        stb_d   = hit;
                        cnt_d   = '0;
                    end else begin
                        state_d   = ST_ACK;
                        ack_d     = 1'b1;
                        dat_d     = ERR_DATA;
                        err_set   = 1'b1;
                        err_adr_d = m_adr_i;
                        err_to_d  = 1'b0;
                    end
                end
            end
            ST_ACTIVE: begin
                // Abort beats ack, and ack beats a coincident timeout.
                if (!m_cyc_i) begin
                    state_d = ST_IDLE;
                    stb_d   = '0;
                end else if (slv_ack) begin
                    state_d = ST_ACK;
                    stb_d   = '0;
                    ack_d   = 1'b1;
                    dat_d   = slv_dat;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_ACK;
                    stb_d     = '0;
                    ack_d     = 1'b1;
                    dat_d     = ERR_DATA;
                    err_set   = 1'b1;
                    err_adr_d = s_adr_o;
                    err_to_d  = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                stb_d   = '0;
            end
        endcase
        // A new error outranks a simultaneous clear.
        flag_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_flag);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            m_ack_o     <= 1'b0;
            m_dat_o     <= '0;
            s_stb_o     <= '0;
            s_adr_o     <= '0;
            s_dat_o     <= '0;
            s_we_o      <= 1'b0;
            s_sel_o     <= '0;
            err_flag    <= 1'b0;
            err_adr     <= '0;
            err_timeout <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            m_ack_o     <= ack_d;
            m_dat_o     <= dat_d;
            s_stb_o     <= stb_d;
            err_flag    <= flag_d;
            err_adr     <= err_adr_d;
            err_timeout <= err_to_d;
            if (ld_bus) begin
                s_adr_o <= m_adr_i;
                s_dat_o <= m_dat_i;
                s_we_o  <= m_we_i;
                s_sel_o <= m_sel_i;
            end
        end
    end

    assign s_cyc_o = s_stb_o;

endmodule

// File: tb/tb_wb_slave_mux.sv
// Directed bench for wb_slave_mux: two slaves split on adr[35:32], TIMEOUT=8.
module tb_wb_slave_mux;

    logic        clk = 1'b0;
    logic        reset;
    logic [35:0] m_adr_i;
    logic [31:0] m_dat_i;
    logic        m_we_i;
    logic [3:0]  m_sel_i;
    logic        m_stb_i;
    logic        m_cyc_i;
    logic [31:0] m_dat_o;
    logic        m_ack_o;
    logic [35:0] s_adr_o;
    logic [31:0] s_dat_o;
    logic        s_we_o;
    logic [3:0]  s_sel_o;
    logic [1:0]  s_stb_o;
    logic [1:0]  s_cyc_o;
    logic [63:0] s_dat_i;
    logic [1:0]  s_ack_i;
    logic        err_flag;
    logic [35:0] err_adr;
    logic        err_timeout;
    logic        err_clr;

    int tests = 0;
    int fails = 0;

    wb_slave_mux #(
        .NSLAVES    (2),
        .SLAVE_BASE ({36'h1_0000_0000, 36'h0_0000_0000}),
        .SLAVE_MASK ({36'hF_0000_0000, 36'hF_0000_0000}),
        .TIMEOUT    (8),
        .ERR_DATA   (32'hDEADBEEF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .m_adr_i     (m_adr_i),
        .m_dat_i     (m_dat_i),
        .m_we_i      (m_we_i),
        .m_sel_i     (m_sel_i),
        .m_stb_i     (m_stb_i),
        .m_cyc_i     (m_cyc_i),
        .m_dat_o     (m_dat_o),
        .m_ack_o     (m_ack_o),
        .s_adr_o     (s_adr_o),
        .s_dat_o     (s_dat_o),
        .s_we_o      (s_we_o),
        .s_sel_o     (s_sel_o),
        .s_stb_o     (s_stb_o),
        .s_cyc_o     (s_cyc_o),
        .s_dat_i     (s_dat_i),
        .s_ack_i     (s_ack_i),
        .err_flag    (err_flag),
        .err_adr     (err_adr),
        .err_timeout (err_timeout),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [35:0] adr, input logic [31:0] dat, input logic we);
        m_adr_i = adr;
        m_dat_i = dat;
        m_we_i  = we;
        m_sel_i = 4'hF;
        m_cyc_i = 1'b1;
        m_stb_i = 1'b1;
    endtask

    task automatic release_bus();
        m_cyc_i = 1'b0;
        m_stb_i = 1'b0;
        s_ack_i = 2'b00;
    endtask

    initial begin
        reset = 1'b1;
        m_adr_i = '0; m_dat_i = '0; m_we_i = 1'b0; m_sel_i = '0;
        m_stb_i = 1'b0; m_cyc_i = 1'b0;
        s_dat_i = '0; s_ack_i = '0; err_clr = 1'b0;
        tick(); tick();
        chk("rst_ack", m_ack_o, 0);
        chk("rst_stb", s_stb_o, 0);
        chk("rst_dat", m_dat_o, 0);
        chk("rst_errflag", err_flag, 0);
        reset = 1'b0;
        tick();

        // Write to slave0, acked one cycle after the strobe appears
        start(36'h0_0000_0010, 32'h12345678, 1'b1);
        tick();
        chk("wr_stb", s_stb_o, 2'b01);
        chk("wr_cyc", s_cyc_o, 2'b01);
        chk("wr_adr", s_adr_o, 36'h0_0000_0010);
        chk("wr_dat", s_dat_o, 32'h12345678);
        chk("wr_we", s_we_o, 1);
        chk("wr_sel", s_sel_o, 4'hF);
        tick();
        chk("wr_noack_early", m_ack_o, 0);
        s_ack_i = 2'b01;
        s_dat_i = {32'h0, 32'h00000055};
        tick();
        chk("wr_ack", m_ack_o, 1);
        chk("wr_stb_drop", s_stb_o, 2'b00);
        chk("wr_errflag", err_flag, 0);
        release_bus();
        tick();
        chk("wr_ack_oneshot", m_ack_o, 0);

        // Read from slave1 after a three-cycle wait
        start(36'h1_0000_0004, 32'h0, 1'b0);
        s_dat_i = {32'hCAFEF00D, 32'h0};
        tick();
        chk("rd_stb", s_stb_o, 2'b10);
        chk("rd_we", s_we_o, 0);
        tick(); tick(); tick();
        chk("rd_wait_noack", m_ack_o, 0);
        chk("rd_wait_stb", s_stb_o, 2'b10);
        s_ack_i = 2'b10;
        tick();
        chk("rd_ack", m_ack_o, 1);
        chk("rd_data", m_dat_o, 32'hCAFEF00D);
        chk("rd_stb_drop", s_stb_o, 2'b00);
        release_bus();
        tick();
        chk("rd_ack_oneshot", m_ack_o, 0);

        // Unmapped address: acked on the sampling edge with error data
        start(36'h2_0000_0000, 32'h0, 1'b0);
        tick();
        chk("um_ack", m_ack_o, 1);
        chk("um_data", m_dat_o, 32'hDEADBEEF);
        chk("um_flag", err_flag, 1);
        chk("um_adr", err_adr, 36'h2_0000_0000);
        chk("um_to", err_timeout, 0);
        chk("um_stb", s_stb_o, 2'b00);
        release_bus();
        tick();
        chk("um_ack_oneshot", m_ack_o, 0);
        chk("um_stb_after", s_stb_o, 2'b00);

        // Timeout: slave0 never answers
        start(36'h0_0000_0000, 32'h0, 1'b0);
        tick();
        chk("to_stb_first", s_stb_o, 2'b01);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("to_stb_held", s_stb_o, 2'b01);
            chk("to_noack", m_ack_o, 0);
        end
        tick();
        chk("to_stb_drop", s_stb_o, 2'b00);
        chk("to_ack", m_ack_o, 1);
        chk("to_data", m_dat_o, 32'hDEADBEEF);
        chk("to_flag", err_flag, 1);
        chk("to_cause", err_timeout, 1);
        chk("to_adr", err_adr, 36'h0_0000_0000);
        release_bus();
        tick();

        // New error coinciding with err_clr keeps the flag set
        err_clr = 1'b1;
        start(36'h3_0000_0040, 32'h0, 1'b0);
        tick();
        chk("clr_race_flag", err_flag, 1);
        chk("clr_race_adr", err_adr, 36'h3_0000_0040);
        chk("clr_race_cause", err_timeout, 0);
        err_clr = 1'b0;
        release_bus();
        tick();
        err_clr = 1'b1;
        tick();
        chk("clr_flag", err_flag, 0);
        chk("clr_adr_kept", err_adr, 36'h3_0000_0040);
        err_clr = 1'b0;

        // Asynchronous reset in the middle of an ACTIVE cycle
        start(36'h1_0000_0008, 32'h0, 1'b0);
        tick();
        chk("ar_stb_pre", s_stb_o, 2'b10);
        #2 reset = 1'b1;
        #1;
        chk("ar_stb", s_stb_o, 2'b00);
        chk("ar_cyc", s_cyc_o, 2'b00);
        chk("ar_sadr", s_adr_o, 0);
        chk("ar_mdat", m_dat_o, 0);
        chk("ar_erradr", err_adr, 0);
        release_bus();
        tick();
        reset = 1'b0;
        tick();
        chk("ar_idle_ack", m_ack_o, 0);

        // Master abort while ACTIVE
        start(36'h0_0000_0020, 32'hAAAA5555, 1'b1);
        tick();
        chk("ab_stb_pre", s_stb_o, 2'b01);
        tick();
        release_bus();
        tick();
        chk("ab_stb", s_stb_o, 2'b00);
        chk("ab_noack", m_ack_o, 0);
        tick();
        chk("ab_noack2", m_ack_o, 0);
        chk("ab_noerr", err_flag, 0);

        // Ack arriving on the timeout cycle wins
        start(36'h0_0000_0050, 32'h0, 1'b0);
        s_dat_i = {32'h0, 32'h600DF00D};
        tick();
        for (int i = 1; i < 8; i++) tick();
        s_ack_i = 2'b01;
        tick();
        chk("race_ack", m_ack_o, 1);
        chk("race_data", m_dat_o, 32'h600DF00D);
        chk("race_noerr", err_flag, 0);
        release_bus();
        tick();

        // Non-selected slave ack is ignored, then a normal read completes
        start(36'h0_0000_0030, 32'h0, 1'b0);
        s_dat_i = {32'h11111111, 32'h13579BDF};
        tick();
        s_ack_i = 2'b10;
        tick();
        chk("fa_noack", m_ack_o, 0);
        chk("fa_stb", s_stb_o, 2'b01);
        s_ack_i = 2'b01;
        tick();
        chk("nm_ack", m_ack_o, 1);
        chk("nm_data", m_dat_o, 32'h13579BDF);
        release_bus();
        tick();
        chk("nm_ack_oneshot", m_ack_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
